// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 decoder among eight requesters.
// It has break-before-make handover (one idle GAP cycle) and an optional hold limit per grant.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] MAX_HOLD_C    = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE      = HOLD_W'(1);
  localparam logic              HOLD_LIMIT_EN = (MAX_HOLD != 0);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        sel_q, sel_d;
  logic              en_q, en_d;
  logic [7:0]        grant_q, grant_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic [3:0]        pick;
  logic              owner_req;
  logic              hold_hit;
  logic              release_now;

  // Returns {found, index}. It scans from p upward with wrap-around, so the
  // requester closest to the pointer wins.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    en_d        = en_q;
    grant_d     = grant_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    pick        = rr_pick(req, ptr_q);
    owner_req   = req[sel_q];
    hold_hit    = HOLD_LIMIT_EN && (hold_cnt_q == MAX_HOLD_C);
    release_now = done || !owner_req || hold_hit;

    case (state_q)
      IDLE: begin
        if (pick[3]) begin
          sel_d      = pick[2:0];
          en_d       = 1'b1;
          grant_d    = 8'b1 << pick[2:0];
          hold_cnt_d = HOLD_ONE;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          en_d      = 1'b0;
          grant_d   = 8'h00;
          ptr_d     = sel_q + 3'd1;
          state_d   = GAP;
          // A done or a withdrawal in the same cycle has priority over the limit.
          timeout_d = hold_hit && !done && owner_req;
        end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        grant_d = 8'h00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      sel_q      <= 3'd0;
      en_q       <= 1'b0;
      grant_q    <= 8'h00;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign en      = en_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
